// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router: header decode, payload, full stall, parity.
// Optional WAIT_TILL_EMPTY timeout with packet drop when ROUTER_FSM_TIMEOUT_EN is defined.
module router_fsm #(
  parameter int WAIT_TIMEOUT = 30,
  parameter int TMO_W        = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       drop_pkt
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_e;

  if ((1 << TMO_W) < WAIT_TIMEOUT) begin : g_tmo_w_check
    $error("router_fsm: TMO_W too narrow for WAIT_TIMEOUT");
  end

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  // Index 3 is the invalid address; padding with 0 keeps every 2-bit index in range.
  logic [3:0] empty_v, sreset_v;
  assign empty_v  = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign sreset_v = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= DA;
      addr_q  <= 2'b00;
`ifdef ROUTER_FSM_TIMEOUT_EN
      cnt_q   <= '0;
      drop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
`ifdef ROUTER_FSM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
`ifdef ROUTER_FSM_TIMEOUT_EN
    cnt_d   = (state_q == WTE) ? cnt_q + TMO_W'(1) : '0;
    drop_d  = 1'b0;
`endif
    if (state_q == DA && pkt_valid) addr_d = data_in;

    case (state_q)
      DA: begin
        if (pkt_valid && data_in != 2'b11) state_d = empty_v[data_in] ? LFD : WTE;
      end
      LFD: state_d = LD;
      LD: begin
        if (fifo_full)       state_d = FFS;
        else if (!pkt_valid) state_d = LP;
      end
      FFS: begin
        if (!fifo_full) state_d = LAF;
      end
      LAF: begin
        if (parity_done)        state_d = DA;
        else if (low_pkt_valid) state_d = LP;
        else                    state_d = LD;
      end
      LP:  state_d = CPE;
      CPE: state_d = fifo_full ? FFS : DA;
      WTE: begin
        if (empty_v[addr_q]) state_d = LFD;
      end
      default: state_d = DA;
    endcase

`ifdef ROUTER_FSM_TIMEOUT_EN
    // A FIFO that drains on the final wait cycle still gets the packet.
    if (state_q == WTE && cnt_q == TMO_W'(WAIT_TIMEOUT - 1) && !empty_v[addr_q]) begin
      state_d = DA;
      drop_d  = 1'b1;
    end
`endif

    if (state_q != DA && sreset_v[addr_q]) begin
      state_d = DA;
`ifdef ROUTER_FSM_TIMEOUT_EN
      drop_d  = 1'b0;
`endif
    end
  end

  assign detect_add    = (state_q == DA);
  assign lfd_state     = (state_q == LFD);
  assign ld_state      = (state_q == LD);
  assign laf_state     = (state_q == LAF);
  assign full_state    = (state_q == FFS);
  assign write_enb_reg = (state_q == LFD) || (state_q == LD) ||
                         (state_q == LP)  || (state_q == LAF);
  assign rst_int_reg   = (state_q == CPE);
  assign busy          = !((state_q == DA) || (state_q == LD));

`ifdef ROUTER_FSM_TIMEOUT_EN
  assign drop_pkt = drop_q;
`else
  assign drop_pkt = 1'b0;
`endif

endmodule
